// File: rtl/logic_analyzer_param.sv
// Parameterised logic analyzer: circular sample capture with pattern/external/forced
// trigger, post-trigger count, and a byte-wide debug bus for control and readback.
module logic_analyzer_param #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      dbus_addr,
  input  logic [7:0]       dbus_write_data,
  input  logic             dbus_write_enable,
  input  logic             dbus_read_enable,
  output logic [7:0]       dbus_read_data,
  output logic             dbus_read_data_valid,
  output logic             dbus_ready,
  input  logic             trigger_in,
  input  logic [WIDTH-1:0] input_data
);

  localparam int DL    = DEPTH_LOG2;
  localparam int DEPTH = 1 << DL;
  localparam int NB    = WIDTH / 8;
  localparam int B     = $clog2(NB);
  localparam int BW    = (B == 0) ? 1 : B;
  localparam logic [DL:0]   FILL_FULL = (DL + 1)'(DEPTH);
  localparam logic [15:0]   P_MAX     = 16'(DEPTH - 1);
  localparam logic [DL-1:0] P_RESET   = DL'(DEPTH / 2);

  typedef enum logic [1:0] {IDLE, ARMED, POST, DONE} state_t;

  state_t           state_q;
  logic [DL-1:0]    wr_ptr_q;
  logic [DL:0]      fill_q;
  logic [DL-1:0]    trig_slot_q;
  logic             triggered_q;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] value_q;
  logic [DL-1:0]    p_q;
  logic [DL-1:0]    p_d;
  logic [DL-1:0]    post_cnt_q;
  logic [7:0]       rd_data_q;
  logic             rd_valid_q;
  logic [WIDTH-1:0] mem [DEPTH];

  logic             ctrl_sel;
  logic [7:0]       reg_a;
  logic             wr_ctrl, arm_w, abort_w, force_w, p_we;
  logic             capturing, pattern_hit, trig_hit;
  logic [DL-1:0]    start_ptr, trig_idx, rd_idx, rd_slot;
  logic [BW-1:0]    byte_sel;
  logic [WIDTH-1:0] rd_word;
  logic [7:0]       mem_byte, rd_byte;
  logic [15:0]      p16, p_cand, fill16, tidx16;

  assign ctrl_sel  = dbus_addr[15];
  assign reg_a     = dbus_addr[7:0];
  assign wr_ctrl   = dbus_write_enable && ctrl_sel && (reg_a == 8'h01);
  assign arm_w     = wr_ctrl && dbus_write_data[0];
  assign abort_w   = wr_ctrl && dbus_write_data[1];
  assign force_w   = wr_ctrl && dbus_write_data[2];
  assign p_we      = dbus_write_enable && ctrl_sel && ((reg_a == 8'h02) || (reg_a == 8'h03));
  assign capturing = (state_q == ARMED) || (state_q == POST);

  assign pattern_hit = (mask_q != '0) && (((input_data ^ value_q) & mask_q) == '0);
  assign trig_hit    = (state_q == ARMED) && (trigger_in || force_w || pattern_hit);

  // Once the buffer has wrapped, the oldest sample sits at the write pointer.
  assign start_ptr = (fill_q == FILL_FULL) ? wr_ptr_q : '0;
  assign trig_idx  = trig_slot_q - start_ptr;

  assign p16    = 16'(p_q);
  assign fill16 = 16'(fill_q);
  assign tidx16 = 16'(trig_idx);

  always_comb begin
    p_cand = p16;
    if (reg_a == 8'h02) p_cand = {dbus_write_data, p16[7:0]};
    else                p_cand = {p16[15:8], dbus_write_data};
    p_d = (p_cand > P_MAX) ? P_MAX[DL-1:0] : p_cand[DL-1:0];
  end

  assign rd_idx   = dbus_addr[B +: DL];
  assign byte_sel = (B == 0) ? '0 : dbus_addr[BW-1:0];
  assign rd_slot  = rd_idx + start_ptr;
  assign rd_word  = mem[rd_slot];

  always_comb begin
    mem_byte = '0;
    for (int k = 0; k < NB; k++) begin
      if (byte_sel == BW'(k)) mem_byte = rd_word[(NB-1-k)*8 +: 8];
    end
  end

  always_comb begin
    rd_byte = '0;
    if (ctrl_sel) begin
      case (reg_a)
        8'h00: rd_byte = {5'b0, (state_q == DONE), triggered_q, capturing};
        8'h02: rd_byte = p16[15:8];
        8'h03: rd_byte = p16[7:0];
        8'h04: rd_byte = fill16[15:8];
        8'h05: rd_byte = fill16[7:0];
        8'h06: rd_byte = tidx16[15:8];
        8'h07: rd_byte = tidx16[7:0];
        default: begin
          for (int k = 0; k < NB; k++) begin
            if (reg_a == 8'(16 + k)) rd_byte = mask_q[(NB-1-k)*8 +: 8];
            if (reg_a == 8'(32 + k)) rd_byte = value_q[(NB-1-k)*8 +: 8];
          end
        end
      endcase
    end else begin
      rd_byte = mem_byte;
    end
  end

  always_ff @(posedge clk) begin
    if (capturing) mem[wr_ptr_q] <= input_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      fill_q      <= '0;
      trig_slot_q <= '0;
      triggered_q <= 1'b0;
      mask_q      <= '0;
      value_q     <= '0;
      p_q         <= P_RESET;
      post_cnt_q  <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      rd_valid_q <= dbus_read_enable;
      if (dbus_read_enable) rd_data_q <= rd_byte;
      if (p_we) p_q <= p_d;
      for (int k = 0; k < NB; k++) begin
        if (dbus_write_enable && ctrl_sel && (reg_a == 8'(16 + k)))
          mask_q[(NB-1-k)*8 +: 8] <= dbus_write_data;
        if (dbus_write_enable && ctrl_sel && (reg_a == 8'(32 + k)))
          value_q[(NB-1-k)*8 +: 8] <= dbus_write_data;
      end

      if (capturing) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
        if (fill_q != FILL_FULL) fill_q <= fill_q + 1'b1;
      end

      // Abort beats arm when both bits arrive in one control write.
      if (abort_w) begin
        state_q <= IDLE;
      end else if (arm_w) begin
        state_q     <= ARMED;
        wr_ptr_q    <= '0;
        fill_q      <= '0;
        triggered_q <= 1'b0;
      end else begin
        case (state_q)
          ARMED: begin
            if (trig_hit) begin
              triggered_q <= 1'b1;
              trig_slot_q <= wr_ptr_q;
              post_cnt_q  <= p_q;
              state_q     <= (p_q == '0) ? DONE : POST;
            end
          end
          POST: begin
            post_cnt_q <= post_cnt_q - 1'b1;
            if (post_cnt_q == DL'(1)) state_q <= DONE;
          end
          default: ;
        endcase
      end
    end
  end

  assign dbus_read_data       = rd_data_q;
  assign dbus_read_data_valid = rd_valid_q;
  assign dbus_ready           = 1'b1;

endmodule

// File: tb/tb_logic_analyzer_param.sv
// Directed bench for logic_analyzer_param (WIDTH=32, DEPTH_LOG2=6); input_data is a
// counter that reads 0 in the first armed cycle.
module tb_logic_analyzer_param;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] dbus_addr = '0;
  logic [7:0]  dbus_write_data = '0;
  logic        dbus_write_enable = 1'b0;
  logic        dbus_read_enable = 1'b0;
  logic [7:0]  dbus_read_data;
  logic        dbus_read_data_valid;
  logic        dbus_ready;
  logic        trigger_in = 1'b0;
  logic [31:0] input_data;
  logic [31:0] cnt = '0;
  logic [31:0] base = '0;

  int checks = 0;
  int errors = 0;

  logic [7:0]  rb;
  logic [31:0] w;

  logic_analyzer_param #(.WIDTH(32), .DEPTH_LOG2(6)) dut (
    .clk                  (clk),
    .reset                (reset),
    .dbus_addr            (dbus_addr),
    .dbus_write_data      (dbus_write_data),
    .dbus_write_enable    (dbus_write_enable),
    .dbus_read_enable     (dbus_read_enable),
    .dbus_read_data       (dbus_read_data),
    .dbus_read_data_valid (dbus_read_data_valid),
    .dbus_ready           (dbus_ready),
    .trigger_in           (trigger_in),
    .input_data           (input_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cnt <= cnt + 1;
  assign input_data = cnt - base;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    dbus_addr = a;
    dbus_write_data = d;
    dbus_write_enable = 1'b1;
    @(negedge clk);
    dbus_write_enable = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [7:0] d);
    dbus_addr = a;
    dbus_read_enable = 1'b1;
    @(negedge clk);
    dbus_read_enable = 1'b0;
    chk("rd_valid", 64'(dbus_read_data_valid), 64'd1);
    d = dbus_read_data;
  endtask

  task automatic rd_chk(input string tag, input logic [15:0] a, input logic [7:0] exp);
    logic [7:0] d;
    bus_read(a, d);
    chk(tag, 64'(d), 64'(exp));
  endtask

  task automatic read_word(input int idx, output logic [31:0] wd);
    logic [7:0] d;
    wd = '0;
    for (int b = 0; b < 4; b++) begin
      bus_read(16'(idx * 4 + b), d);
      wd = {wd[23:0], d};
    end
  endtask

  task automatic arm();
    base = cnt + 1;
    bus_write(16'h8001, 8'h01);
  endtask

  task automatic wait_done(input string tag);
    logic [7:0] d;
    logic done;
    done = 1'b0;
    for (int n = 0; n < 300 && !done; n++) begin
      bus_read(16'h8000, d);
      done = d[2];
    end
    chk(tag, 64'(done), 64'd1);
  endtask

  task automatic wait_input(input string tag, input logic [31:0] v);
    for (int n = 0; n < 300 && input_data != v; n++) @(negedge clk);
    chk(tag, 64'(input_data), 64'(v));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state and read timing
    chk("rst_valid", 64'(dbus_read_data_valid), 64'd0);
    chk("rst_rdata", 64'(dbus_read_data), 64'd0);
    chk("ready", 64'(dbus_ready), 64'd1);
    rd_chk("rst_status", 16'h8000, 8'h00);
    rd_chk("rst_p_msb", 16'h8002, 8'h00);
    rd_chk("rst_p_lsb", 16'h8003, 8'h20);
    @(negedge clk);
    chk("valid_one_cycle", 64'(dbus_read_data_valid), 64'd0);
    chk("rdata_hold", 64'(dbus_read_data), 64'h20);
    rd_chk("rst_mask3", 16'h8013, 8'h00);
    rd_chk("unmapped_30", 16'h8030, 8'h00);
    rd_chk("wo_ctrl", 16'h8001, 8'h00);

    // P clamping to DEPTH-1
    bus_write(16'h8002, 8'h01);
    rd_chk("p_clamp_msb", 16'h8002, 8'h00);
    rd_chk("p_clamp_lsb", 16'h8003, 8'h3F);
    bus_write(16'h8002, 8'h00);
    bus_write(16'h8003, 8'h05);
    rd_chk("p5", 16'h8003, 8'h05);

    // Pattern trigger on 0x50, P=5, buffer wraps
    for (int k = 0; k < 4; k++) bus_write(16'h8010 + 16'(k), 8'hFF);
    bus_write(16'h8020, 8'h00);
    bus_write(16'h8021, 8'h00);
    bus_write(16'h8022, 8'h00);
    bus_write(16'h8023, 8'h50);
    rd_chk("value3", 16'h8023, 8'h50);
    arm();
    rd_chk("armed_status", 16'h8000, 8'h01);
    wait_done("pat_done");
    rd_chk("pat_status", 16'h8000, 8'h06);
    rd_chk("pat_fill_msb", 16'h8004, 8'h00);
    rd_chk("pat_fill_lsb", 16'h8005, 8'h40);
    rd_chk("pat_tidx_lsb", 16'h8007, 8'd58);
    read_word(58, w); chk("pat_s58", 64'(w), 64'h50);
    read_word(63, w); chk("pat_s63", 64'(w), 64'h55);
    read_word(0, w);  chk("pat_s0", 64'(w), 64'h16);
    rd_chk("pat_byte_lsb", 16'(4 * 58 + 3), 8'h50);
    rd_chk("pat_byte_msb", 16'(4 * 58), 8'h00);

    // Forced trigger at sample 9, no wrap
    arm();
    wait_input("force_wait", 32'd9);
    bus_write(16'h8001, 8'h04);
    wait_done("force_done");
    rd_chk("force_fill", 16'h8005, 8'd15);
    rd_chk("force_tidx", 16'h8007, 8'd9);
    read_word(0, w);  chk("force_s0", 64'(w), 64'h00);
    read_word(14, w); chk("force_s14", 64'(w), 64'h0E);

    // External trigger with P=0 at sample 0x80
    for (int k = 0; k < 4; k++) bus_write(16'h8010 + 16'(k), 8'h00);
    bus_write(16'h8003, 8'h00);
    arm();
    wait_input("ext_wait", 32'h80);
    trigger_in = 1'b1;
    @(negedge clk);
    trigger_in = 1'b0;
    rd_chk("ext_status", 16'h8000, 8'h06);
    rd_chk("ext_fill", 16'h8005, 8'h40);
    rd_chk("ext_tidx", 16'h8007, 8'd63);
    read_word(63, w); chk("ext_s63", 64'(w), 64'h80);
    read_word(0, w);  chk("ext_s0", 64'(w), 64'h41);

    // Abort during POST, then arm+abort together
    bus_write(16'h8003, 8'h28);
    arm();
    wait_input("abort_wait", 32'd3);
    bus_write(16'h8001, 8'h04);
    repeat (3) @(negedge clk);
    bus_write(16'h8001, 8'h02);
    rd_chk("abort_status", 16'h8000, 8'h02);
    rd_chk("abort_fill", 16'h8005, 8'd8);
    rd_chk("abort_tidx", 16'h8007, 8'd3);
    repeat (5) @(negedge clk);
    rd_chk("abort_fill_stable", 16'h8005, 8'd8);
    read_word(7, w); chk("abort_s7", 64'(w), 64'h07);
    bus_write(16'h8001, 8'h03);
    rd_chk("armabort_status", 16'h8000, 8'h02);
    rd_chk("armabort_fill", 16'h8005, 8'd8);

    // Reset pulse mid-POST
    bus_write(16'h8013, 8'h01);
    bus_write(16'h8023, 8'h01);
    arm();
    wait_input("rst_wait", 32'd5);
    rd_chk("pre_rst_status", 16'h8000, 8'h03);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_valid2", 64'(dbus_read_data_valid), 64'd0);
    chk("rst_rdata2", 64'(dbus_read_data), 64'd0);
    repeat (3) @(negedge clk);
    rd_chk("rst2_status", 16'h8000, 8'h00);
    rd_chk("rst2_p_msb", 16'h8002, 8'h00);
    rd_chk("rst2_p_lsb", 16'h8003, 8'h20);
    rd_chk("rst2_mask3", 16'h8013, 8'h00);
    rd_chk("rst2_value3", 16'h8023, 8'h00);
    rd_chk("rst2_fill", 16'h8005, 8'h00);
    rd_chk("rst2_tidx", 16'h8007, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
